// File: rtl/pc_stall_monitor_if.sv
// rtl/pc_stall_monitor_if.sv - sample/control/status bundle between a CPU-side driver and the PC stall monitor
interface pc_stall_monitor_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
);
  logic              en;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  threshold;
  logic              clear;
  logic              stalled;
  logic              trip_pulse;
  logic [ADDR_W-1:0] stall_pc;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output en, pc, threshold, clear,
    input  stalled, trip_pulse, stall_pc, stall_count
  );

  modport slave (
    input  en, pc, threshold, clear,
    output stalled, trip_pulse, stall_pc, stall_count
  );
endinterface

// File: rtl/pc_stall_monitor.sv
// rtl/pc_stall_monitor.sv - idle/loop PC watchdog; PC_STALL_LOOP_DETECT_EN enables multi-entry loop history
module pc_stall_monitor #(
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 8,
  parameter int HIST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  pc_stall_monitor_if.slave bus
);

`ifdef PC_STALL_LOOP_DETECT_EN
  localparam int DEPTH = HIST_DEPTH;
`else
  // Single-entry mode: only an unchanged/self-jump PC counts, HIST_DEPTH has no effect.
  localparam int DEPTH = (HIST_DEPTH >= 1) ? 1 : 1;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  state_t            state;
  logic              stalled_q;
  logic              trip_q;
  logic [ADDR_W-1:0] spc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] hist [DEPTH];
  logic [DEPTH-1:0]  hist_valid;

  logic              hit;
  logic              thr_zero;
  logic              shift_en;
  logic [CNT_W-1:0]  cnt_next;

  // Hit detection against the valid history entries, plus saturating next count.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hist_valid[i] && (hist[i] == bus.pc)) hit = 1'b1;
    end
    thr_zero = (bus.threshold == '0);
    cnt_next = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    // A miss shifts history in both IDLE and RUN; TRIPPED freezes it.
    shift_en = !reset && !bus.clear && (state != TRIPPED) && bus.en && !hit;
  end

  // History shift register; reset and clear throw away everything seen so far.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      hist_valid <= '0;
    end else if (shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        hist[i]       <= hist[i-1];
        hist_valid[i] <= hist_valid[i-1];
      end
      hist[0]       <= bus.pc;
      hist_valid[0] <= 1'b1;
    end
  end

  // Monitor FSM: counts consecutive hits, trips on exact threshold match, holds until clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= thr_zero ? IDLE : RUN;
      stalled_q <= 1'b0;
      trip_q    <= 1'b0;
      spc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      trip_q <= 1'b0;
      if (bus.clear) begin
        state     <= thr_zero ? IDLE : RUN;
        stalled_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        case (state)
          TRIPPED: begin
            // Frozen until clear.
          end
          default: begin
            if (thr_zero) begin
              state <= IDLE;
              cnt_q <= '0;
            end else begin
              state <= RUN;
              if (bus.en) begin
                if (hit) begin
                  cnt_q <= cnt_next;
                  if (cnt_next == bus.threshold) begin
                    state     <= TRIPPED;
                    stalled_q <= 1'b1;
                    trip_q    <= 1'b1;
                    spc_q     <= bus.pc;
                  end
                end else begin
                  cnt_q <= '0;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.stalled     = stalled_q;
  assign bus.trip_pulse  = trip_q;
  assign bus.stall_pc    = spc_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: doc/pc_stall_monitor.md
# pc_stall_monitor

Synthesizable, parametrised successor to the bench-only idle-PC watchdog used around the 6502 `cpu` core. It samples the CPU program counter on qualified cycles and counts consecutive samples that revisit a recently seen PC. Three cases are detected: a self-jump, an unchanged PC, or, when configured, a tight loop of up to `HIST_DEPTH` distinct addresses. When the count reaches a runtime threshold it raises a sticky stall flag and captures the offending PC, for use by benches (`$finish` hook) and by on-chip debug logic.

## Interface
- `ADDR_W`, 16, PC width.
- `CNT_W`, 8, stall counter and threshold width.
- `HIST_DEPTH`, 4, number of recent distinct PCs held for loop detection (≥1).

- `clk`  in  1  core clock (same clock as `cpu`).
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  sample qualifier (e.g. opcode-fetch/sync); `pc` is ignored when 0.
- `pc`  in  `ADDR_W`  program counter to monitor.
- `threshold`  in  `CNT_W`  hit count that trips the monitor; 0 disables it.
- `clear`  in  1  clears the trip and re-arms the monitor.
- `stalled`  out  1  sticky trip flag.
- `trip_pulse`  out  1  single-cycle pulse on trip.
- `stall_pc`  out  `ADDR_W`  PC of the sample that caused the trip.
- `stall_count`  out  `CNT_W`  current consecutive-hit count.

## Operation
- History: shift register `hist[0..HIST_DEPTH-1]` with a valid bit per entry. `hist[0]` is the newest entry.
- States:
  - IDLE: `threshold==0`.
  - RUN.
  - TRIPPED.
- In RUN with `en=1`:
  - A hit is `pc` matching any valid entry (the compare set depends on the macro).
  - Hit: `stall_count` increments, saturating at 2^CNT_W−1. History is unchanged.
  - Miss: `stall_count` is set to 0, `pc` is shifted into `hist[0]` and marked valid, and the oldest entry is dropped.
- Trip: the next count equals `threshold` while in RUN.
  - Go to TRIPPED.
  - `stalled`←1, `stall_pc`←`pc`, `trip_pulse`=1 for one cycle.
- In TRIPPED: count, history and `stall_pc` are frozen; `en` is ignored.
- `clear`:
  - Sets `stalled`=0 and count=0, and invalidates all history.
  - Goes to RUN, or IDLE if `threshold==0`.
- `threshold` becoming 0 in RUN: go to IDLE and zero the count. History is kept and compares resume on return to RUN.
- In IDLE: history still updates on misses; the count stays 0.
- `threshold` lowered below the current count: no trip until the count is reset by a miss and climbs to the new value. Trip requires exact equality.

## Timing
- All outputs are registered. A sample at edge N updates `stall_count`, `stalled`, `stall_pc` and `trip_pulse` at edge N; they are visible during cycle N→N+1.
- `trip_pulse` is high for exactly one cycle, coincident with `stalled` first going high.
- Reset values: `stalled`=0, `trip_pulse`=0, `stall_pc`=0, `stall_count`=0, all history invalid, state RUN/IDLE per `threshold`.
- Reset takes priority over everything. `clear` takes priority over a trip on the same cycle: no pulse, `stalled` stays 0.
- Reset or `clear` in the middle of counting discards all accumulated history.
- The first sample after reset or clear is always a miss. Holding a constant PC therefore trips on sample `threshold`+1.

## Configuration
- `PC_STALL_LOOP_DETECT_EN`:
  - Defined: hit compares `pc` against all `HIST_DEPTH` valid entries, detecting loops of up to `HIST_DEPTH` distinct PCs.
  - Undefined: only `hist[0]` is compared and only one entry is implemented. Only an unchanged or self-jump PC counts, as in the original watchdog. `HIST_DEPTH` is ignored.

## Test plan
- Constant pc=0x1234, `en`=1 every cycle, `threshold`=4 → `stalled`=1 and `trip_pulse` high for one cycle after the 5th sample; `stall_pc`=0x1234, `stall_count`=4; both hold until `clear`.
- Incrementing pc 0x0000–0x00FF, `threshold`=3 → `stall_count` stays 0 and `stalled` never asserts.
- Alternating pc 0xF000/0xF002, `threshold`=6:
  - Macro defined: trips after sample 8 (2 misses + 6 hits), `stall_pc`=0xF002.
  - Macro undefined: never trips.
- Constant pc, `en` high every 4th cycle, `threshold`=2 → trips on the 3rd enabled sample; `stall_count` is unchanged on `en`=0 cycles.
- `clear` asserted on the cycle that would trip → `stalled`=0, `trip_pulse`=0, count=0. Re-holding the same PC then trips after `threshold`+1 samples.
- `reset` at count=3 → all outputs 0 next cycle. With `threshold`=0 and constant pc for 300 samples → never trips, count stays 0.
